// File: rtl/ps2_rx_fifo_if.sv
// rtl/ps2_rx_fifo_if.sv - PS/2 pin inputs and receive-FIFO read-side signal bundle
interface ps2_rx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          ps2_data;
    logic          ps2_clock;
    logic          rd_en;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [CW-1:0] fifo_count;
    logic          parity_err;
    logic          frame_err;
    logic          overflow;

    modport master (
        output ps2_data, ps2_clock, rd_en,
        input  rx_data, rx_valid, fifo_count, parity_err, frame_err, overflow
    );

    modport slave (
        input  ps2_data, ps2_clock, rd_en,
        output rx_data, rx_valid, fifo_count, parity_err, frame_err, overflow
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 keyboard frame receiver with glitch filter and byte FIFO
module ps2_rx_fifo #(
    parameter int FILTER_LEN     = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CHECK_PARITY   = 1
) (
    input logic          CLOCK_50,
    input logic          rst,
    ps2_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RX, CHECK} state_t;

    logic [1:0]            data_sync;
    logic                  data_s;
    logic [FILTER_LEN-1:0] clk_shreg;
    logic                  clk_level;
    logic                  fall;

    state_t                state;
    logic [9:0]            frame_sr;
    logic [3:0]            bit_cnt;
    logic [TW-1:0]         to_cnt;
    logic                  parity_err_q;
    logic                  frame_err_q;
    logic                  overflow_q;

    logic [7:0]            mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  parity_bad;
    logic                  push_req;
    logic                  pop;
    logic                  push_ok;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            data_sync <= '0;
        end else begin
            data_sync <= {data_sync[0], bus.ps2_data};
        end
    end

    assign data_s = data_sync[1];

    // The clock line is only trusted once FILTER_LEN samples agree; mixed samples hold the level.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            clk_shreg <= '0;
            clk_level <= 1'b0;
            fall      <= 1'b0;
        end else begin
            clk_shreg <= {clk_shreg[FILTER_LEN-2:0], bus.ps2_clock};
            fall      <= clk_level && (clk_shreg == '0);
            if (&clk_shreg) begin
                clk_level <= 1'b1;
            end else if (clk_shreg == '0) begin
                clk_level <= 1'b0;
            end
        end
    end

    // Odd parity: data plus parity bit must carry an odd number of ones.
    assign parity_bad = (CHECK_PARITY != 0) && !(^frame_sr[8:0]);
    assign push_req   = (state == CHECK) && frame_sr[9] && !parity_bad;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            frame_sr     <= '0;
            bit_cnt      <= '0;
            to_cnt       <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall && !data_s) begin
                        state   <= RX;
                        bit_cnt <= '0;
                        to_cnt  <= '0;
                    end
                end
                RX: begin
                    if (fall) begin
                        frame_sr <= {data_s, frame_sr[9:1]};
                        bit_cnt  <= bit_cnt + 4'd1;
                        to_cnt   <= '0;
                        if (bit_cnt == 4'd9) begin
                            state <= CHECK;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        frame_err_q <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    if (!frame_sr[9]) begin
                        frame_err_q <= 1'b1;
                    end else if (parity_bad) begin
                        parity_err_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A pop in the same cycle frees the slot, so a push at full still succeeds.
    assign pop     = bus.rd_en && (count != '0);
    assign push_ok = push_req && ((count != FULL) || pop);

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= push_req && !push_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (push_ok) begin
            mem[wr_ptr] <= frame_sr[7:0];
        end
    end

    assign bus.rx_data    = (count != '0) ? mem[rd_ptr] : 8'h00;
    assign bus.rx_valid   = (count != '0);
    assign bus.fifo_count = count;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - self-checking bench for ps2_rx_fifo
module tb_ps2_rx_fifo;
    localparam int FILT  = 8;
    localparam int DEPTH = 16;
    localparam int TO    = 300;

    logic clk;
    logic rst;
    logic ps2_data;
    logic ps2_clock;
    logic rd_a;
    logic rd_b;

    int n_cmp  = 0;
    int n_fail = 0;
    int perr_a = 0;
    int ferr_a = 0;
    int ovf_a  = 0;
    int excl_bad = 0;
    int rdv_cnt = 0;
    logic [7:0] rdv_data = 8'h00;

    ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus_a ();
    ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus_b ();

    assign bus_a.ps2_data  = ps2_data;
    assign bus_a.ps2_clock = ps2_clock;
    assign bus_a.rd_en     = rd_a;
    assign bus_b.ps2_data  = ps2_data;
    assign bus_b.ps2_clock = ps2_clock;
    assign bus_b.rd_en     = rd_b;

    ps2_rx_fifo #(.FILTER_LEN(FILT), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .CHECK_PARITY(1))
        dut_a (.CLOCK_50(clk), .rst(rst), .bus(bus_a));
    ps2_rx_fifo #(.FILTER_LEN(FILT), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .CHECK_PARITY(0))
        dut_b (.CLOCK_50(clk), .rst(rst), .bus(bus_b));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (bus_a.parity_err) perr_a++;
        if (bus_a.frame_err) ferr_a++;
        if (bus_a.overflow) ovf_a++;
        if (int'(bus_a.parity_err) + int'(bus_a.frame_err) + int'(bus_a.overflow) > 1) excl_bad++;
        if (rd_a && bus_a.rx_valid) begin
            rdv_cnt++;
            rdv_data = bus_a.rx_data;
        end
    end

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         stop;
        int         glitch;
        int         d_perr;
        int         d_ferr;
        int         exp_cnt;
        logic [7:0] exp_head;
    } vec_t;

    logic [7:0] mq[$];

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(2);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop,
                              input int nbits, input int glitch_bit, input bit pop_chk);
        logic [10:0] bits;
        logic par;
        par  = bad_par ? ^d : ~^d;
        bits = {stop, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            cyc(5);
            ps2_data = bits[i];
            cyc(5);
            if (glitch_bit == i) begin
                ps2_clock = 1'b0;
                cyc(FILT - 1);
                ps2_clock = 1'b1;
            end
            cyc(10);
            ps2_clock = 1'b0;
            if (pop_chk && i == 10) begin
                cyc(10);
                rd_a = 1'b1;
                cyc(1);
                rd_a = 1'b0;
                cyc(9);
            end else begin
                cyc(20);
            end
            ps2_clock = 1'b1;
        end
        ps2_data = 1'b1;
        cyc(30);
    endtask

    task automatic pop_a();
        rd_a = 1'b1;
        cyc(1);
        rd_a = 1'b0;
    endtask

    function automatic int model_head();
        return (mq.size() > 0) ? int'(mq[0]) : 0;
    endfunction

    vec_t vt[7];
    int p0, f0, o0;
    logic [7:0] d;
    bit bp, st;

    initial begin
        ps2_data  = 1'b1;
        ps2_clock = 1'b1;
        rd_a      = 1'b0;
        rd_b      = 1'b0;
        do_reset();

        chk("reset_rx_data", int'(bus_a.rx_data), 0);
        chk("reset_rx_valid", int'(bus_a.rx_valid), 0);
        chk("reset_count", int'(bus_a.fifo_count), 0);
        chk("reset_err_pulses", perr_a + ferr_a + ovf_a, 0);

        vt[0] = '{8'h1C, 0, 1, -1, 0, 0, 1, 8'h1C};
        vt[1] = '{8'h1C, 1, 1, -1, 1, 0, 1, 8'h1C};
        vt[2] = '{8'hF0, 0, 0, -1, 0, 1, 1, 8'h1C};
        vt[3] = '{8'hA5, 0, 1,  0, 0, 0, 2, 8'h1C};
        vt[4] = '{8'h3C, 0, 1,  4, 0, 0, 3, 8'h1C};
        vt[5] = '{8'h00, 0, 1, -1, 0, 0, 4, 8'h1C};
        vt[6] = '{8'h55, 1, 1, -1, 1, 0, 4, 8'h1C};
        for (int i = 0; i < 7; i++) begin
            p0 = perr_a; f0 = ferr_a;
            send_frame(vt[i].data, vt[i].bad_par, vt[i].stop, 11, vt[i].glitch, 1'b0);
            chk($sformatf("vec%0d_perr", i), perr_a - p0, vt[i].d_perr);
            chk($sformatf("vec%0d_ferr", i), ferr_a - f0, vt[i].d_ferr);
            chk($sformatf("vec%0d_count", i), int'(bus_a.fifo_count), vt[i].exp_cnt);
            chk($sformatf("vec%0d_head", i), int'(bus_a.rx_data), int'(vt[i].exp_head));
        end
        chk("nopar_count", int'(bus_b.fifo_count), 6);
        rd_b = 1'b1; cyc(1); rd_b = 1'b0;
        chk("nopar_second", int'(bus_b.rx_data), 8'h1C);

        mq = '{8'h1C, 8'hA5, 8'h3C, 8'h00};
        while (mq.size() > 0) begin
            void'(mq.pop_front());
            pop_a();
            chk("drain_head", int'(bus_a.rx_data), model_head());
            chk("drain_count", int'(bus_a.fifo_count), mq.size());
        end
        pop_a();
        chk("rd_empty_count", int'(bus_a.fifo_count), 0);
        chk("rd_empty_data", int'(bus_a.rx_data), 0);
        chk("rd_empty_valid", int'(bus_a.rx_valid), 0);

        f0 = ferr_a;
        send_frame(8'hF0, 1'b0, 1'b1, 6, -1, 1'b0);
        cyc(TO + 20);
        chk("timeout_ferr", ferr_a - f0, 1);
        chk("timeout_count", int'(bus_a.fifo_count), 0);
        send_frame(8'hF0, 1'b0, 1'b1, 11, -1, 1'b0);
        chk("after_to_head", int'(bus_a.rx_data), 8'hF0);
        pop_a();

        send_frame(8'h99, 1'b0, 1'b1, 5, -1, 1'b0);
        rst = 1'b1; cyc(2);
        chk("midrst_count", int'(bus_a.fifo_count), 0);
        rst = 1'b0; cyc(2);
        p0 = perr_a; f0 = ferr_a;
        send_frame(8'h3A, 1'b0, 1'b1, 11, -1, 1'b0);
        chk("midrst_head", int'(bus_a.rx_data), 8'h3A);
        chk("midrst_count1", int'(bus_a.fifo_count), 1);
        chk("midrst_errs", (perr_a - p0) + (ferr_a - f0), 0);

        do_reset();
        mq.delete();
        o0 = ovf_a;
        for (int v = 1; v <= DEPTH + 1; v++) begin
            send_frame(8'(v), 1'b0, 1'b1, 11, -1, 1'b0);
            if (mq.size() < DEPTH) mq.push_back(8'(v));
        end
        chk("full_count", int'(bus_a.fifo_count), DEPTH);
        chk("full_ovf", ovf_a - o0, 1);
        chk("full_head", int'(bus_a.rx_data), 8'h01);
        send_frame(8'h42, 1'b0, 1'b1, 11, -1, 1'b1);
        void'(mq.pop_front());
        mq.push_back(8'h42);
        chk("full_pushpop_count", int'(bus_a.fifo_count), DEPTH);
        chk("full_pushpop_ovf", ovf_a - o0, 1);
        while (mq.size() > 0) begin
            chk("full_order", int'(bus_a.rx_data), model_head());
            void'(mq.pop_front());
            pop_a();
        end
        chk("full_drained", int'(bus_a.fifo_count), 0);

        rdv_cnt = 0;
        rd_a = 1'b1;
        send_frame(8'h77, 1'b0, 1'b1, 11, -1, 1'b0);
        rd_a = 1'b0;
        chk("empty_pushpop_cycles", rdv_cnt, 1);
        chk("empty_pushpop_data", int'(rdv_data), 8'h77);
        chk("empty_pushpop_count", int'(bus_a.fifo_count), 0);

        do_reset();
        mq.delete();
        for (int n = 0; n < 24; n++) begin
            d  = 8'($urandom);
            bp = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 6) != 0);
            p0 = perr_a; f0 = ferr_a; o0 = ovf_a;
            send_frame(d, bp, st, 11, -1, 1'b0);
            chk("rnd_ferr", ferr_a - f0, st ? 0 : 1);
            chk("rnd_perr", perr_a - p0, (st && bp) ? 1 : 0);
            chk("rnd_ovf", ovf_a - o0, (st && !bp && mq.size() == DEPTH) ? 1 : 0);
            if (st && !bp && mq.size() < DEPTH) mq.push_back(d);
            chk("rnd_count", int'(bus_a.fifo_count), mq.size());
            chk("rnd_head", int'(bus_a.rx_data), model_head());
            if ($urandom_range(0, 2) == 0) begin
                if (mq.size() > 0) void'(mq.pop_front());
                pop_a();
                chk("rnd_pop_head", int'(bus_a.rx_data), model_head());
            end
        end

        chk("pulse_exclusive", excl_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
